audio_rec_sequencer: RTL and testbench

Upstream control stage for the DDR2 RAM wrapper in the audio recorder. In record mode it takes 8-bit audio samples from the capture path and writes them to sequential RAM addresses from 0. In playback mode it reads the recorded samples back in order and presents them to the output path. It drives the wrapper's byte handshake (address, data_in, write_enable, read_request, read_ack, data_out, rdy, rd_data_pres).

---
 rtl/audio_rec_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_audio_rec_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_rec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : audio_rec_sequencer
// Purpose  : Record/playback sequencer driving the DDR2 wrapper byte handshake.
// Revision : 1.0
// ============================================================================
module audio_rec_sequencer #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rec,
    input  logic              play,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    input  logic              sample_req,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    output logic              read_request,
    output logic              read_ack,
    input  logic [DATA_W-1:0] data_out,
    input  logic              rdy,
    input  logic              rd_data_pres,
    input  logic [ADDR_W-1:0] max_ram_address,
    output logic [ADDR_W-1:0] rec_len,
    output logic              recording,
    output logic              playing,
    output logic              full,
    output logic              overrun
);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_rec_wait  = 3'd1;
    localparam logic [2:0] c_rec_write = 3'd2;
    localparam logic [2:0] c_play_wait = 3'd3;
    localparam logic [2:0] c_play_req  = 3'd4;
    localparam logic [2:0] c_play_data = 3'd5;
    localparam logic [2:0] c_done      = 3'd6;

    localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              write_enable_q, write_enable_d;
    logic              read_request_q, read_request_d;
    logic              read_ack_q, read_ack_d;
    logic              sample_out_valid_q, sample_out_valid_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;

    logic [ADDR_W-1:0] w_last_addr;
    logic              w_drain;
    logic              w_cap_en;
    logic              w_done_exit;

    assign w_last_addr = rec_len_q - c_one;
    assign w_drain     = rdy && (state_q == c_rec_wait) && pend_q;
    // Capture stays armed in DONE while rec is held so post-full samples register as overruns.
    assign w_cap_en    = recording || ((state_q == c_done) && rec);
    assign w_done_exit = rdy && (state_q == c_done) && !rec && !play;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q            <= c_idle;
            address_q          <= '0;
            rec_len_q          <= '0;
            data_in_q          <= '0;
            sample_out_q       <= '0;
            hold_q             <= '0;
            write_enable_q     <= 1'b0;
            read_request_q     <= 1'b0;
            read_ack_q         <= 1'b0;
            sample_out_valid_q <= 1'b0;
            full_q             <= 1'b0;
            overrun_q          <= 1'b0;
            pend_q             <= 1'b0;
            req_q              <= 1'b0;
        end else begin
            state_q            <= state_d;
            address_q          <= address_d;
            rec_len_q          <= rec_len_d;
            data_in_q          <= data_in_d;
            sample_out_q       <= sample_out_d;
            hold_q             <= hold_d;
            write_enable_q     <= write_enable_d;
            read_request_q     <= read_request_d;
            read_ack_q         <= read_ack_d;
            sample_out_valid_q <= sample_out_valid_d;
            full_q             <= full_d;
            overrun_q          <= overrun_d;
            pend_q             <= pend_d;
            req_q              <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                c_idle: begin
                    if (rec)
                        state_d = c_rec_wait;
                    else if (play)
                        state_d = (rec_len_q != '0) ? c_play_wait : c_done;
                end
                c_rec_wait: begin
                    if (pend_q)
                        state_d = c_rec_write;
                    else if (!rec)
                        state_d = c_idle;
                end
                c_rec_write:
                    state_d = (address_q == max_ram_address) ? c_done : c_rec_wait;
                c_play_wait: begin
                    if (req_q)
                        state_d = c_play_req;
                    else if (!play)
                        state_d = c_idle;
                end
                c_play_req: begin
                    if (rd_data_pres)
                        state_d = c_play_data;
                end
                c_play_data:
                    state_d = (address_q == w_last_addr) ? c_done : c_play_wait;
                c_done: begin
                    if (!rec && !play)
                        state_d = c_idle;
                end
                default: state_d = c_idle;
            endcase
        end
    end

    always_comb begin
        address_d          = address_q;
        rec_len_d          = rec_len_q;
        data_in_d          = data_in_q;
        sample_out_d       = sample_out_q;
        hold_d             = hold_q;
        write_enable_d     = 1'b0;
        read_request_d     = 1'b0;
        read_ack_d         = 1'b0;
        sample_out_valid_d = 1'b0;
        full_d             = full_q;
        overrun_d          = overrun_q;
        pend_d             = pend_q;
        req_d              = req_q;

        if (rdy) begin
            case (state_q)
                c_idle: begin
                    if (rec) begin
                        rec_len_d = '0;
                        full_d    = 1'b0;
                        overrun_d = 1'b0;
                        address_d = '0;
                    end else if (play && (rec_len_q != '0)) begin
                        address_d = '0;
                    end
                end
                c_rec_wait: begin
                    if (pend_q) begin
                        data_in_d      = hold_q;
                        write_enable_d = 1'b1;
                    end
                end
                c_rec_write: begin
                    if (rec_len_q <= max_ram_address)
                        rec_len_d = rec_len_q + c_one;
                    if (address_q == max_ram_address)
                        full_d = 1'b1;
                    else
                        address_d = address_q + c_one;
                end
                c_play_wait: begin
                    if (req_q)
                        read_request_d = 1'b1;
                end
                c_play_req: begin
                    if (rd_data_pres) begin
                        sample_out_d       = data_out;
                        read_ack_d         = 1'b1;
                        sample_out_valid_d = 1'b1;
                    end
                end
                c_play_data: begin
                    if (address_q != w_last_addr)
                        address_d = address_q + c_one;
                end
                default: ;
            endcase
        end

        // Hold buffer: a sample landing on the draining cycle refills it without an overrun.
        if (state_q == c_idle) begin
            if (!rec)
                pend_d = 1'b0;
            else if (sample_in_valid) begin
                hold_d = sample_in;
                pend_d = 1'b1;
            end
        end else begin
            if (w_drain)
                pend_d = 1'b0;
            if (w_cap_en && sample_in_valid) begin
                if (full_q || (pend_q && !w_drain))
                    overrun_d = 1'b1;
                else begin
                    hold_d = sample_in;
                    pend_d = 1'b1;
                end
            end
            if (w_done_exit)
                pend_d = 1'b0;
        end

        if (playing) begin
            if (read_request_d)
                req_d = 1'b0;
            if (sample_req)
                req_d = 1'b1;
        end else begin
            req_d = 1'b0;
        end
    end

    assign recording        = (state_q == c_rec_wait) || (state_q == c_rec_write);
    assign playing          = (state_q == c_play_wait) || (state_q == c_play_req) ||
                              (state_q == c_play_data);
    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;
    assign address          = address_q;
    assign data_in          = data_in_q;
    assign write_enable     = write_enable_q;
    assign read_request     = read_request_q;
    assign read_ack         = read_ack_q;
    assign rec_len          = rec_len_q;
    assign full             = full_q;
    assign overrun          = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_rec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_rec_sequencer
// Purpose  : Directed scoreboard bench for audio_rec_sequencer with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_audio_rec_sequencer;

    logic        CLK;
    logic        reset;
    logic        rec;
    logic        play;
    logic [7:0]  sample_in;
    logic        sample_in_valid;
    logic        sample_req;
    logic [7:0]  sample_out;
    logic        sample_out_valid;
    logic [25:0] address;
    logic [7:0]  data_in;
    logic        write_enable;
    logic        read_request;
    logic        read_ack;
    logic [7:0]  data_out;
    logic        rdy;
    logic        rd_data_pres;
    logic [25:0] max_ram_address;
    logic [25:0] rec_len;
    logic        recording;
    logic        playing;
    logic        full;
    logic        overrun;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rrq_cnt = 0;
    int ack_cnt = 0;
    int sov_cnt = 0;
    int rd_lat = 3;
    int lat_cnt = 0;
    int base_wr, base_rrq, base_ack, base_sov;

    logic [33:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  mem [0:1023];

    audio_rec_sequencer dut (
        .CLK              (CLK),
        .reset            (reset),
        .rec              (rec),
        .play             (play),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_req       (sample_req),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .address          (address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .read_request     (read_request),
        .read_ack         (read_ack),
        .data_out         (data_out),
        .rdy              (rdy),
        .rd_data_pres     (rd_data_pres),
        .max_ram_address  (max_ram_address),
        .rec_len          (rec_len),
        .recording        (recording),
        .playing          (playing),
        .full             (full),
        .overrun          (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] d);
        sample_in       = d;
        sample_in_valid = 1'b1;
        tick(1);
        sample_in_valid = 1'b0;
    endtask

    task automatic send_req();
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
    endtask

    // RAM wrapper model: rd_data_pres pulses rd_lat cycles after a read strobe.
    always @(posedge CLK) begin
        if (reset) begin
            lat_cnt      <= 0;
            rd_data_pres <= 1'b0;
        end else begin
            rd_data_pres <= 1'b0;
            if (read_request)
                lat_cnt <= rd_lat;
            else if (lat_cnt > 1)
                lat_cnt <= lat_cnt - 1;
            else if (lat_cnt == 1) begin
                lat_cnt      <= 0;
                rd_data_pres <= 1'b1;
                data_out     <= mem[address[9:0]];
            end
        end
    end

    // Scoreboard side: pops expectations as the DUT strobes.
    always @(negedge CLK) begin
        if (!reset) begin
            if (write_enable) begin
                wr_cnt++;
                check("wr_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    logic [33:0] e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(address), 32'(e[33:8]));
                    check("wr_data", 32'(data_in), 32'(e[7:0]));
                end
                mem[address[9:0]] = data_in;
            end
            if (read_request) rrq_cnt++;
            if (read_ack) ack_cnt++;
            if (sample_out_valid) begin
                sov_cnt++;
                check("rd_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    logic [7:0] e8;
                    e8 = rq.pop_front();
                    check("rd_data", 32'(sample_out), 32'(e8));
                end
            end
        end
    end

    initial begin
        logic [7:0] vals [0:4];
        reset = 1'b1; rec = 1'b0; play = 1'b0; sample_in = '0; sample_in_valid = 1'b0;
        sample_req = 1'b0; rdy = 1'b1; data_out = '0; max_ram_address = 26'd1000;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        tick(3);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_rec_len", 32'(rec_len), 32'd0);
        check("rst_strobes", {28'd0, write_enable, read_request, read_ack, sample_out_valid}, 32'd0);
        check("rst_flags", {28'd0, recording, playing, full, overrun}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Record 4 samples
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        rec = 1'b1;
        tick(2);
        check("rec_recording", 32'(recording), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wq.push_back({26'(i), vals[i]});
            send_sample(vals[i]);
            tick(9);
        end
        rec = 1'b0;
        tick(4);
        check("rec4_wr_cnt", 32'(wr_cnt), 32'd4);
        check("rec4_rec_len", 32'(rec_len), 32'd4);
        check("rec4_idle", {30'd0, recording, playing}, 32'd0);
        check("rec4_flags", {30'd0, full, overrun}, 32'd0);

        // Playback of the 4 samples, then a 5th request that must be ignored
        base_rrq = rrq_cnt; base_ack = ack_cnt; base_sov = sov_cnt;
        play = 1'b1;
        tick(2);
        check("play_playing", 32'(playing), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rq.push_back(vals[i]);
            send_req();
            tick(11);
        end
        check("play_rrq", 32'(rrq_cnt - base_rrq), 32'd4);
        check("play_ack", 32'(ack_cnt - base_ack), 32'd4);
        check("play_sov", 32'(sov_cnt - base_sov), 32'd4);
        check("play_done", 32'(playing), 32'd0);
        send_req();
        tick(10);
        check("play_5th_no_read", 32'(rrq_cnt - base_rrq), 32'd4);
        play = 1'b0;
        tick(3);

        // Full: only addresses 0..2 written
        max_ram_address = 26'd2;
        base_wr = wr_cnt;
        rec = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) wq.push_back({26'(i), 8'hA1 + 8'(i)});
            send_sample(8'hA1 + 8'(i));
            tick(9);
        end
        check("full_wr_cnt", 32'(wr_cnt - base_wr), 32'd3);
        check("full_flag", 32'(full), 32'd1);
        check("full_overrun", 32'(overrun), 32'd1);
        check("full_rec_len", 32'(rec_len), 32'd3);
        rec = 1'b0;
        tick(3);

        // rdy gating with a second sample dropped while pending
        max_ram_address = 26'd1000;
        rec = 1'b1;
        tick(3);
        check("gate_overrun_clr", 32'(overrun), 32'd0);
        base_wr = wr_cnt;
        rdy = 1'b0;
        tick(1);
        wq.push_back({26'd0, 8'h55});
        send_sample(8'h55);
        tick(3);
        send_sample(8'h66);
        tick(15);
        check("gate_no_write", 32'(wr_cnt - base_wr), 32'd0);
        check("gate_overrun", 32'(overrun), 32'd1);
        rdy = 1'b1;
        tick(5);
        check("gate_write_after", 32'(wr_cnt - base_wr), 32'd1);
        check("gate_rec_len", 32'(rec_len), 32'd1);
        rec = 1'b0;
        tick(3);

        // Priority: rec wins over play
        rec = 1'b1; play = 1'b1;
        tick(2);
        check("prio_recording", {30'd0, recording, playing}, 32'd2);
        rec = 1'b0; play = 1'b0;
        tick(3);

        // Async reset in PLAY_REQ
        rec = 1'b1;
        tick(2);
        wq.push_back({26'd0, 8'h77});
        send_sample(8'h77);
        tick(5);
        rec = 1'b0;
        tick(3);
        check("ar_rec_len", 32'(rec_len), 32'd1);
        rd_lat = 40;
        base_rrq = rrq_cnt;
        play = 1'b1;
        tick(2);
        send_req();
        for (int i = 0; i < 20 && rrq_cnt == base_rrq; i++) tick(1);
        check("ar_read_issued", 32'(rrq_cnt - base_rrq), 32'd1);
        tick(3);
        check("ar_in_play", 32'(playing), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_flags", {28'd0, recording, playing, full, overrun}, 32'd0);
        check("ar_rec_len0", 32'(rec_len), 32'd0);
        check("ar_data_in", {8'd0, data_in, sample_out, 8'(address)}, 32'd0);
        check("ar_strobes", {28'd0, write_enable, read_request, read_ack, sample_out_valid}, 32'd0);
        tick(2);
        reset = 1'b0;
        play = 1'b0;
        rd_lat = 3;
        tick(3);
        check("ar_idle", {30'd0, recording, playing}, 32'd0);

        // Empty playback after reset goes to DONE without a read
        base_rrq = rrq_cnt;
        play = 1'b1;
        tick(2);
        send_req();
        tick(8);
        check("empty_no_read", 32'(rrq_cnt - base_rrq), 32'd0);
        check("empty_not_playing", 32'(playing), 32'd0);
        play = 1'b0;
        tick(3);

        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
